// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage sitting directly after execute.
//
// Accepts one execute record at a time, performs at most one load or store
// over a req/gnt/rvalid data-memory port, aligns and extends load data, and
// holds one registered writeback record behind a valid/ready handshake.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           execute-side handshake
//   pc_in, alu_result, rs2_in,    execute record: PC, address-or-result,
//   rd_in, func3_in, memR_in,     store data, destination, access size/sign,
//   memW_in, regW_in              load/store/register-write controls
//   out_valid / out_ready         writeback-side handshake
//   pc_out, wb_data, rd_out,      registered writeback record
//   regW_out, fault
//   dmem_req, dmem_we, dmem_addr, data-memory request channel
//   dmem_be, dmem_wdata, dmem_gnt
//   dmem_rvalid, dmem_rdata       data-memory response channel
module mem_access #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] pc_in,
    input  logic [DWIDTH-1:0] alu_result,
    input  logic [DWIDTH-1:0] rs2_in,
    input  logic [4:0]        rd_in,
    input  logic [2:0]        func3_in,
    input  logic              memR_in,
    input  logic              memW_in,
    input  logic              regW_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] pc_out,
    output logic [DWIDTH-1:0] wb_data,
    output logic [4:0]        rd_out,
    output logic              regW_out,
    output logic              fault,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DWIDTH-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DWIDTH-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DWIDTH-1:0] dmem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state_q, state_d;

    // Working copy of the accepted record, used while the bus access runs.
    logic [DWIDTH-1:0] pc_q, pc_d, addr_q, addr_d, rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;
    logic [2:0]        func3_q, func3_d;
    logic              memw_q, memw_d, regw_q, regw_d;

    // Writeback output registers.
    logic              out_valid_q, out_valid_d;
    logic [DWIDTH-1:0] pc_out_q, pc_out_d, wb_data_q, wb_data_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic              regw_out_q, regw_out_d, fault_q, fault_d;

    logic              in_fault;

    // Misalignment, illegal size encodings, and load+store together.
    // func3 011 is treated as illegal for stores as well (no doubleword).
    function automatic logic access_fault(input logic rd_op, input logic wr_op,
                                          input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        bad = rd_op && wr_op;
        if (rd_op && (f3 == 3'b011 || f3[2:1] == 2'b11)) bad = 1'b1;
        if (wr_op && (f3[2] || f3 == 3'b011))            bad = 1'b1;
        if ((rd_op || wr_op) && f3[1:0] == 2'b01 && a[0])         bad = 1'b1;
        if ((rd_op || wr_op) && f3[1:0] == 2'b10 && a != 2'b00)   bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across lanes so the enabled lanes carry it.
    function automatic logic [DWIDTH-1:0] store_data(input logic [1:0] size,
                                                     input logic [DWIDTH-1:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [DWIDTH-1:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                      input logic [DWIDTH-1:0] word);
        logic signed [7:0]        b;
        logic signed [15:0]       h;
        logic signed [DWIDTH-1:0] ext;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  ext = b;
            3'b001:  ext = h;
            3'b100:  ext = {{(DWIDTH-8){1'b0}}, b};
            3'b101:  ext = {{(DWIDTH-16){1'b0}}, h};
            default: ext = word;
        endcase
        return ext;
    endfunction

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign in_fault = access_fault(memR_in, memW_in, func3_in, alu_result[1:0]);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        func3_d     = func3_q;
        memw_d      = memw_q;
        regw_d      = regw_q;
        out_valid_d = out_valid_q;
        pc_out_d    = pc_out_q;
        wb_data_d   = wb_data_q;
        rd_out_d    = rd_out_q;
        regw_out_d  = regw_out_q;
        fault_d     = fault_q;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_addr   = '0;
        dmem_be     = 4'b0000;
        dmem_wdata  = '0;

        // A consumed record clears; any result loaded below overrides this.
        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    pc_d    = pc_in;
                    addr_d  = alu_result;
                    rs2_d   = rs2_in;
                    rd_d    = rd_in;
                    func3_d = func3_in;
                    memw_d  = memW_in;
                    regw_d  = regW_in;
                    if (!(memR_in || memW_in) || in_fault) begin
                        out_valid_d = 1'b1;
                        pc_out_d    = pc_in;
                        wb_data_d   = alu_result;
                        rd_out_d    = rd_in;
                        regw_out_d  = regW_in && !in_fault;
                        fault_d     = in_fault;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                dmem_req   = 1'b1;
                dmem_we    = memw_q;
                dmem_addr  = {addr_q[DWIDTH-1:2], 2'b00};
                dmem_be    = lane_be(func3_q[1:0], addr_q[1:0]);
                dmem_wdata = memw_q ? store_data(func3_q[1:0], rs2_q) : '0;
                if (dmem_gnt) begin
                    if (memw_q) begin
                        out_valid_d = 1'b1;
                        pc_out_d    = pc_q;
                        wb_data_d   = addr_q;
                        rd_out_d    = rd_q;
                        regw_out_d  = regw_q;
                        fault_d     = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    out_valid_d = 1'b1;
                    pc_out_d    = pc_q;
                    wb_data_d   = load_extend(func3_q, addr_q[1:0], dmem_rdata);
                    rd_out_d    = rd_q;
                    regw_out_d  = regw_q;
                    fault_d     = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and visible outputs are reset; the working copy is only
    // observed through the bus outputs, which are gated by state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            pc_out_q    <= '0;
            wb_data_q   <= '0;
            rd_out_q    <= '0;
            regw_out_q  <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            pc_out_q    <= pc_out_d;
            wb_data_q   <= wb_data_d;
            rd_out_q    <= rd_out_d;
            regw_out_q  <= regw_out_d;
            fault_q     <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        addr_q  <= addr_d;
        rs2_q   <= rs2_d;
        rd_q    <= rd_d;
        func3_q <= func3_d;
        memw_q  <= memw_d;
        regw_q  <= regw_d;
    end

    assign out_valid = out_valid_q;
    assign pc_out    = pc_out_q;
    assign wb_data   = wb_data_q;
    assign rd_out    = rd_out_q;
    assign regW_out  = regw_out_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: scoreboard of expected writeback records and
// expected bus requests, fed by a byte-level reference memory model; a bus
// responder with its own word memory; directed cases then random traffic.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] pc_in, alu_result, rs2_in;
    logic [4:0]  rd_in;
    logic [2:0]  func3_in;
    logic        memR_in, memW_in, regW_in;
    logic        out_valid, out_ready;
    logic [31:0] pc_out, wb_data;
    logic [4:0]  rd_out;
    logic        regW_out, fault;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;

    mem_access #(.DWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .alu_result(alu_result), .rs2_in(rs2_in), .rd_in(rd_in),
        .func3_in(func3_in), .memR_in(memR_in), .memW_in(memW_in), .regW_in(regW_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .wb_data(wb_data), .rd_out(rd_out), .regW_out(regW_out), .fault(fault),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        regw;
        logic        flt;
    } out_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    out_t        sb[$];
    bus_t        exp_bus[$];
    logic [7:0]  refmem[0:1023];
    logic [31:0] bmem[0:255];
    int          checks = 0;
    int          errors = 0;
    int          gdly = 2;
    int          rdly = 0;
    bit          stray_rv = 1'b0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Reference: bytes are read/written individually at the byte address.
    task automatic model(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic [2:0] f3,
                         input logic r, input logic w, input logic rw);
        out_t        o;
        bus_t        b;
        logic        flt;
        int          sz, a;
        logic [31:0] v;
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        flt = r && w;
        if (r && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) flt = 1'b1;
        if (w && f3 >= 3'd3) flt = 1'b1;
        if ((r || w) && (alu & 32'(sz - 1)) != 0) flt = 1'b1;
        o.pc = pc; o.rd = rd; o.wb = alu; o.flt = flt;
        o.regw = flt ? 1'b0 : rw;
        a = int'(alu[9:0]);
        b.addr = {alu[31:2], 2'b00};
        b.be = 4'b0000;
        if (!flt && w) begin
            b.we = 1'b1;
            for (int k = 0; k < sz; k++) begin
                b.be[(a % 4) + k] = 1'b1;
                refmem[a + k] = rs2[8*k +: 8];
            end
            b.wdata = (sz == 1) ? {4{rs2[7:0]}} : (sz == 2) ? {2{rs2[15:0]}} : rs2;
            exp_bus.push_back(b);
        end else if (!flt && r) begin
            b.we = 1'b0;
            b.wdata = 32'h0;
            v = 32'h0;
            for (int k = 0; k < sz; k++) begin
                b.be[(a % 4) + k] = 1'b1;
                v[8*k +: 8] = refmem[a + k];
            end
            if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
            o.wb = v;
            exp_bus.push_back(b);
        end
        sb.push_back(o);
    endtask

    // Present one record and hold it until accepted (bounded).
    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic [2:0] f3,
                         input logic r, input logic w, input logic rw, input bit rnd_ready);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; pc_in = pc; alu_result = alu; rs2_in = rs2; rd_in = rd;
        func3_in = f3; memR_in = r; memW_in = w; regW_in = rw;
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) model(pc, alu, rs2, rd, f3, r, w, rw);
            @(posedge clk); #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 9) < 7);
        end
        in_valid = 1'b0;
        if (!acc) bad("accept_timeout", "record not accepted within 60 cycles");
    endtask

    // Scoreboard monitor: compare each record as it is handed over.
    initial begin
        out_t e, act;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                act = {pc_out, wb_data, rd_out, regW_out, fault};
                if (sb.size() == 0) begin
                    bad("unexpected_out", $sformatf("got record %0h, required none", act));
                end else begin
                    e = sb.pop_front();
                    chk("wb_record", 128'(act), 128'(e));
                end
            end
        end
    end

    // Bus responder with its own word memory.
    initial begin
        bit   req_seen, rd_pend;
        int   wait_cnt, tgt, rd_cnt;
        int   rd_idx, idx;
        bus_t cap, cur, e;
        req_seen = 0; rd_pend = 0; wait_cnt = 0; tgt = 0; rd_cnt = 0; rd_idx = 0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            if (rst) begin
                req_seen = 0; rd_pend = 0;
            end else begin
                if (stray_rv) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata = 32'hA5A5_1234;
                end
                if (rd_pend) begin
                    if (rd_cnt == 0) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata = bmem[rd_idx];
                        rd_pend = 0;
                    end else begin
                        rd_cnt--;
                    end
                end
                cur = {dmem_we, dmem_addr, dmem_be, dmem_wdata};
                if (dmem_req) begin
                    if (!req_seen) begin
                        req_seen = 1; wait_cnt = 0; cap = cur;
                        tgt = (gdly < 0) ? int'($urandom_range(0, 3)) : gdly;
                    end else begin
                        chk("req_stable", 128'(cur), 128'(cap));
                    end
                    if (wait_cnt >= tgt) begin
                        dmem_gnt = 1'b1;
                        req_seen = 0;
                        idx = int'(dmem_addr[9:2]);
                        if (exp_bus.size() == 0) begin
                            bad("unexpected_req", $sformatf("got request %0h, required none", cur));
                        end else begin
                            e = exp_bus.pop_front();
                            chk("bus_req", 128'(cur), 128'(e));
                        end
                        if (dmem_we) begin
                            for (int k = 0; k < 4; k++)
                                if (dmem_be[k]) bmem[idx][8*k +: 8] = dmem_wdata[8*k +: 8];
                        end else begin
                            rd_pend = 1; rd_idx = idx;
                            rd_cnt = (rdly < 0) ? int'($urandom_range(0, 3)) : rdly;
                        end
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    req_seen = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        int          t0, kind, gap;
        logic [31:0] ralu;
        logic [2:0]  rf3;

        for (int i = 0; i < 256; i++) begin
            w = (i == 32'h40) ? 32'h80AA_55CC : $urandom;
            bmem[i] = w;
            for (int k = 0; k < 4; k++) refmem[4*i + k] = w[8*k +: 8];
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        pc_in = 0; alu_result = 0; rs2_in = 0; rd_in = 0; func3_in = 0;
        memR_in = 0; memW_in = 0; regW_in = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_req", 128'(dmem_req), 128'(0));
        chk("rst_wb_outs", 128'({pc_out, wb_data, rd_out, regW_out, fault}), 128'(0));
        chk("rst_bus_outs", 128'({dmem_we, dmem_addr, dmem_be, dmem_wdata}), 128'(0));
        @(posedge clk); #1;

        // Non-memory passthrough and back-to-back streaming
        out_ready = 1'b1;
        issue(32'h40, 32'h1234, 32'h0, 5'd5, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("pass_valid", 128'(out_valid), 128'(1));
        chk("pass_wb", 128'(wb_data), 128'(32'h0000_1234));
        chk("pass_rd", 128'(rd_out), 128'(5));
        @(posedge clk); #1;
        t0 = cyc;
        for (int i = 0; i < 4; i++)
            issue(32'h100 + 32'(4*i), $urandom, 32'h0, 5'(i + 1), 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stream_rate", 128'(cyc - t0), 128'(4));

        // LB / LBU at 0x103: grant after 2 cycles, data 1 cycle later
        for (int s = 0; s < 2; s++) begin
            issue(32'h200 + 32'(s), 32'h103, 32'h0, 5'd7, s ? 3'b100 : 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("lb_req", 128'(dmem_req), 128'(1));
                chk("lb_addr_be", 128'({dmem_addr, dmem_be}), 128'({32'h100, 4'b1000}));
                chk("lb_in_ready", 128'(in_ready), 128'(0));
            end
            @(negedge clk);
            chk("lb_resp_in_ready", 128'(in_ready), 128'(0));
            @(negedge clk);
            chk("lb_wb", 128'({out_valid, wb_data}), 128'({1'b1, s ? 32'h0000_0080 : 32'hFFFF_FF80}));
            @(posedge clk); #1;
        end

        // SH to upper half
        issue(32'h300, 32'h202, 32'hDEAD_BEEF, 5'd8, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sh_bus", 128'({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata}),
                128'({1'b1, 1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF}));
        end
        @(negedge clk);
        chk("sh_out_valid", 128'(out_valid), 128'(1));
        @(posedge clk); #1;

        // Faults: misaligned LW, illegal load func3
        issue(32'h400, 32'h101, 32'h0, 5'd9, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("flt_lw", 128'({dmem_req, out_valid, fault, regW_out}), 128'({1'b0, 1'b1, 1'b1, 1'b0}));
        @(posedge clk); #1;
        issue(32'h404, 32'h104, 32'h0, 5'd9, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("flt_f3", 128'({dmem_req, fault, regW_out}), 128'({1'b0, 1'b1, 1'b0}));
        @(posedge clk); #1;

        // Output backpressure
        out_ready = 1'b0;
        issue(32'h500, 32'hA5A5, 32'h0, 5'd9, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1; pc_in = 32'h504; alu_result = 32'h5A5A; rs2_in = 0; rd_in = 5'd10;
        func3_in = 3'd0; memR_in = 0; memW_in = 0; regW_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold", 128'({out_valid, wb_data, rd_out, in_ready}),
                128'({1'b1, 32'hA5A5, 5'd9, 1'b0}));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 128'(in_ready), 128'(1));
        if (in_ready) model(32'h504, 32'h5A5A, 32'h0, 5'd10, 3'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next", 128'({out_valid, wb_data, rd_out}), 128'({1'b1, 32'h5A5A, 5'd10}));
        @(posedge clk); #1;

        // Reset while waiting for load data, then a stray rvalid
        gdly = 0; rdly = 20;
        issue(32'h600, 32'h10, 32'h0, 5'd3, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("rstl_in_resp", 128'({dmem_req, in_ready}), 128'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_bus.delete();
        @(negedge clk);
        chk("rstl_state", 128'({dmem_req, out_valid, in_ready}), 128'({1'b0, 1'b0, 1'b1}));
        chk("rstl_outs", 128'({pc_out, wb_data, rd_out, regW_out, fault}), 128'(0));
        @(posedge clk); #1;
        stray_rv = 1'b1;
        @(posedge clk); #1;
        stray_rv = 1'b0;
        @(negedge clk);
        chk("stray_rvalid", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
        @(posedge clk); #1;

        // Random traffic
        gdly = -1; rdly = -1;
        for (int n = 0; n < 300; n++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 9) < 7);
            end
            kind = int'($urandom_range(0, 9));
            ralu = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 0) ralu[1:0] = 2'b00;
            rf3 = 3'($urandom_range(0, 7));
            if (kind < 4)
                issue($urandom, $urandom, $urandom, 5'($urandom), rf3, 1'b0, 1'b0, 1'($urandom), 1'b1);
            else if (kind < 7)
                issue($urandom, ralu, $urandom, 5'($urandom), rf3, 1'b1, 1'b0, 1'($urandom), 1'b1);
            else if (kind < 9)
                issue($urandom, ralu, $urandom, 5'($urandom), (rf3 == 3'd3) ? 3'd2 : rf3,
                      1'b0, 1'b1, 1'($urandom), 1'b1);
            else
                issue($urandom, ralu, $urandom, 5'($urandom), rf3, 1'b1, 1'b1, 1'($urandom), 1'b1);
        end

        out_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_records", 128'(sb.size()), 128'(0));
        chk("drain_bus", 128'(exp_bus.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
